// File: rtl/sram_icb_arb_pkg.sv
// Shared types and constants for the two-master ICB arbiter in front of the SRAM slave.
package sram_icb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WRSP = 2'd2
    } arb_state_e;

    localparam int ICB_ADDR_W = 32;
    localparam int ICB_DATA_W = 32;

    // Master index encoding used by grant, owner and last_gnt.
    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

endpackage

// File: rtl/sram_icb_rr2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the master not granted last.
module sram_icb_rr2
    import sram_icb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt
);

    always_comb begin
        gnt = MST_M0;
        if (req == 2'b11) begin
            gnt = ~last_gnt;
        end else if (req[1]) begin
            gnt = MST_M1;
        end
    end

endmodule

// File: rtl/sram_icb_arb.sv
// Shares one SRAM ICB slave between m0 (fetch) and m1 (load/store), one transaction in flight,
// with write responses generated locally because the slave only responds to reads.
module sram_icb_arb
    import sram_icb_arb_pkg::*;
#(
    parameter int ADDR_W = ICB_ADDR_W,
    parameter int DATA_W = ICB_DATA_W
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_icb_cmd_valid,
    output logic                m0_icb_cmd_ready,
    input  logic [ADDR_W-1:0]   m0_icb_cmd_addr,
    input  logic                m0_icb_cmd_read,
    input  logic [DATA_W-1:0]   m0_icb_cmd_wdata,
    input  logic [DATA_W/8-1:0] m0_icb_cmd_wmask,
    output logic                m0_icb_rsp_valid,
    input  logic                m0_icb_rsp_ready,
    output logic                m0_icb_rsp_err,
    output logic [DATA_W-1:0]   m0_icb_rsp_rdata,

    input  logic                m1_icb_cmd_valid,
    output logic                m1_icb_cmd_ready,
    input  logic [ADDR_W-1:0]   m1_icb_cmd_addr,
    input  logic                m1_icb_cmd_read,
    input  logic [DATA_W-1:0]   m1_icb_cmd_wdata,
    input  logic [DATA_W/8-1:0] m1_icb_cmd_wmask,
    output logic                m1_icb_rsp_valid,
    input  logic                m1_icb_rsp_ready,
    output logic                m1_icb_rsp_err,
    output logic [DATA_W-1:0]   m1_icb_rsp_rdata,

    output logic                s_icb_cmd_valid,
    input  logic                s_icb_cmd_ready,
    output logic [ADDR_W-1:0]   s_icb_cmd_addr,
    output logic                s_icb_cmd_read,
    output logic [DATA_W-1:0]   s_icb_cmd_wdata,
    output logic [DATA_W/8-1:0] s_icb_cmd_wmask,
    input  logic                s_icb_rsp_valid,
    output logic                s_icb_rsp_ready,
    input  logic                s_icb_rsp_err,
    input  logic [DATA_W-1:0]   s_icb_rsp_rdata,

    output arb_state_e          dbg_state
);

    arb_state_e        state;
    logic              owner;
    logic              last_gnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_err_q;
    logic              rst_q;

    logic              gnt;
    logic              is_idle;
    logic              blocked;
    logic              cmd_hs;
    logic              own_rsp_ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    sram_icb_rr2 u_rr2 (
        .req      ({m1_icb_cmd_valid, m0_icb_cmd_valid}),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    assign is_idle   = (state == ARB_IDLE);
    // No command may be accepted during reset or in the first cycle after it.
    assign blocked   = rst | rst_q;
    assign cmd_hs    = s_icb_cmd_valid & s_icb_cmd_ready;
    assign dbg_state = state;

    always_comb begin
        s_icb_cmd_valid  = 1'b0;
        s_icb_cmd_addr   = addr_q;
        s_icb_cmd_read   = 1'b0;
        s_icb_cmd_wdata  = '0;
        s_icb_cmd_wmask  = '0;
        m0_icb_cmd_ready = 1'b0;
        m1_icb_cmd_ready = 1'b0;
        if (is_idle) begin
            if (gnt == MST_M1) begin
                s_icb_cmd_valid  = m1_icb_cmd_valid & ~blocked;
                s_icb_cmd_addr   = m1_icb_cmd_addr;
                s_icb_cmd_read   = m1_icb_cmd_read;
                s_icb_cmd_wdata  = m1_icb_cmd_wdata;
                s_icb_cmd_wmask  = m1_icb_cmd_wmask;
                m1_icb_cmd_ready = s_icb_cmd_ready & ~blocked;
            end else begin
                s_icb_cmd_valid  = m0_icb_cmd_valid & ~blocked;
                s_icb_cmd_addr   = m0_icb_cmd_addr;
                s_icb_cmd_read   = m0_icb_cmd_read;
                s_icb_cmd_wdata  = m0_icb_cmd_wdata;
                s_icb_cmd_wmask  = m0_icb_cmd_wmask;
                m0_icb_cmd_ready = s_icb_cmd_ready & ~blocked;
            end
        end
    end

    assign own_rsp_ready = (owner == MST_M1) ? m1_icb_rsp_ready : m0_icb_rsp_ready;

    always_comb begin
        rsp_valid       = 1'b0;
        rsp_err         = 1'b0;
        rsp_rdata       = '0;
        s_icb_rsp_ready = 1'b0;
        case (state)
            // Stray slave responses (e.g. left over from an abandoned read) are swallowed here.
            ARB_IDLE: s_icb_rsp_ready = 1'b1;
            ARB_RD: begin
                rsp_valid       = s_icb_rsp_valid;
                rsp_err         = s_icb_rsp_err;
                rsp_rdata       = s_icb_rsp_rdata;
                s_icb_rsp_ready = own_rsp_ready;
            end
            ARB_WRSP: begin
                rsp_valid = 1'b1;
                rsp_err   = wr_err_q;
            end
            default: s_icb_rsp_ready = 1'b0;
        endcase
        if (rst) begin
            rsp_valid = 1'b0;
        end
    end

    always_comb begin
        m0_icb_rsp_valid = 1'b0;
        m0_icb_rsp_err   = 1'b0;
        m0_icb_rsp_rdata = '0;
        m1_icb_rsp_valid = 1'b0;
        m1_icb_rsp_err   = 1'b0;
        m1_icb_rsp_rdata = '0;
        if (owner == MST_M1) begin
            m1_icb_rsp_valid = rsp_valid;
            m1_icb_rsp_err   = rsp_err;
            m1_icb_rsp_rdata = rsp_rdata;
        end else begin
            m0_icb_rsp_valid = rsp_valid;
            m0_icb_rsp_err   = rsp_err;
            m0_icb_rsp_rdata = rsp_rdata;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state    <= ARB_IDLE;
            owner    <= MST_M0;
            last_gnt <= MST_M1;
            addr_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (cmd_hs) begin
                        owner    <= gnt;
                        last_gnt <= gnt;
                        addr_q   <= s_icb_cmd_addr;
                        if (s_icb_cmd_read) begin
                            state <= ARB_RD;
                        end else begin
                            // Slave err is combinational on the address, so it is valid right now.
                            state    <= ARB_WRSP;
                            wr_err_q <= s_icb_rsp_err;
                        end
                    end
                end
                ARB_RD: begin
                    if (s_icb_rsp_valid && s_icb_rsp_ready) begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_WRSP: begin
                    if (own_rsp_ready) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_icb_arb.sv
// Directed bench for sram_icb_arb with a small behavioural SRAM slave behind it.
module tb_sram_icb_arb;
    import sram_icb_arb_pkg::*;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int SRAM_SIZE = 256;

    logic          clk;
    logic          rst;
    logic          slv_rst;

    logic          m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
    logic [AW-1:0] m0_cmd_addr;
    logic [DW-1:0] m0_cmd_wdata;
    logic [3:0]    m0_cmd_wmask;
    logic          m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [DW-1:0] m0_rsp_rdata;

    logic          m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
    logic [AW-1:0] m1_cmd_addr;
    logic [DW-1:0] m1_cmd_wdata;
    logic [3:0]    m1_cmd_wmask;
    logic          m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [DW-1:0] m1_rsp_rdata;

    logic          s_cmd_valid, s_cmd_ready, s_cmd_read;
    logic [AW-1:0] s_cmd_addr;
    logic [DW-1:0] s_cmd_wdata;
    logic [3:0]    s_cmd_wmask;
    logic          s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [DW-1:0] s_rsp_rdata;
    arb_state_e    dbg_state;

    int            n_checks;
    int            n_errors;
    logic [0:0]    exp_q[$];

    sram_icb_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .m0_icb_cmd_valid (m0_cmd_valid),
        .m0_icb_cmd_ready (m0_cmd_ready),
        .m0_icb_cmd_addr  (m0_cmd_addr),
        .m0_icb_cmd_read  (m0_cmd_read),
        .m0_icb_cmd_wdata (m0_cmd_wdata),
        .m0_icb_cmd_wmask (m0_cmd_wmask),
        .m0_icb_rsp_valid (m0_rsp_valid),
        .m0_icb_rsp_ready (m0_rsp_ready),
        .m0_icb_rsp_err   (m0_rsp_err),
        .m0_icb_rsp_rdata (m0_rsp_rdata),
        .m1_icb_cmd_valid (m1_cmd_valid),
        .m1_icb_cmd_ready (m1_cmd_ready),
        .m1_icb_cmd_addr  (m1_cmd_addr),
        .m1_icb_cmd_read  (m1_cmd_read),
        .m1_icb_cmd_wdata (m1_cmd_wdata),
        .m1_icb_cmd_wmask (m1_cmd_wmask),
        .m1_icb_rsp_valid (m1_rsp_valid),
        .m1_icb_rsp_ready (m1_rsp_ready),
        .m1_icb_rsp_err   (m1_rsp_err),
        .m1_icb_rsp_rdata (m1_rsp_rdata),
        .s_icb_cmd_valid  (s_cmd_valid),
        .s_icb_cmd_ready  (s_cmd_ready),
        .s_icb_cmd_addr   (s_cmd_addr),
        .s_icb_cmd_read   (s_cmd_read),
        .s_icb_cmd_wdata  (s_cmd_wdata),
        .s_icb_cmd_wmask  (s_cmd_wmask),
        .s_icb_rsp_valid  (s_rsp_valid),
        .s_icb_rsp_ready  (s_rsp_ready),
        .s_icb_rsp_err    (s_rsp_err),
        .s_icb_rsp_rdata  (s_rsp_rdata),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- SRAM slave model ----------------
    logic [DW-1:0] mem [0:SRAM_SIZE/4-1];
    logic          srsp_err_q;
    logic          in_range;

    assign s_cmd_ready = 1'b1;
    assign in_range    = (s_cmd_addr < SRAM_SIZE);
    assign s_rsp_err   = s_rsp_valid ? srsp_err_q : ~in_range;

    always @(posedge clk) begin
        if (slv_rst) begin
            s_rsp_valid <= 1'b0;
            s_rsp_rdata <= '0;
            srsp_err_q  <= 1'b0;
            for (int i = 0; i < SRAM_SIZE/4; i++) mem[i] <= '0;
            mem[32'h10 >> 2] <= 32'hDEADBEEF;
            mem[32'h20 >> 2] <= 32'h12345678;
            mem[32'h30 >> 2] <= 32'hCAFE0001;
            mem[32'h34 >> 2] <= 32'hCAFE0002;
        end else begin
            if (s_rsp_valid && s_rsp_ready) s_rsp_valid <= 1'b0;
            if (s_cmd_valid && s_cmd_ready) begin
                if (s_cmd_read) begin
                    s_rsp_valid <= 1'b1;
                    s_rsp_rdata <= in_range ? mem[s_cmd_addr[7:2]] : '0;
                    srsp_err_q  <= ~in_range;
                end else if (in_range) begin
                    for (int b = 0; b < 4; b++)
                        if (s_cmd_wmask[b]) mem[s_cmd_addr[7:2]][b*8 +: 8] <= s_cmd_wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cmd(input int m, input logic v, input logic rd, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [3:0] wm);
        if (m == 0) begin
            m0_cmd_valid = v; m0_cmd_read = rd; m0_cmd_addr = a; m0_cmd_wdata = wd; m0_cmd_wmask = wm;
        end else begin
            m1_cmd_valid = v; m1_cmd_read = rd; m1_cmd_addr = a; m1_cmd_wdata = wd; m1_cmd_wmask = wm;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full transaction from a lone master; checks response exactly one cycle after handshake.
    task automatic do_txn(input string tag, input int m, input logic rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [3:0] wm,
                          input logic [DW-1:0] exp_rdata, input logic exp_err);
        logic rdy;
        rdy = 1'b0;
        drive_cmd(m, 1'b1, rd, a, wd, wm);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rdy = (m == 0) ? m0_cmd_ready : m1_cmd_ready;
            if (rdy) break;
            step();
        end
        check({tag, "_cmd_ready"}, rdy, 1);
        step();
        drive_cmd(m, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        if (m == 0) begin
            check({tag, "_rsp_valid"}, m0_rsp_valid, 1);
            check({tag, "_rdata"}, m0_rsp_rdata, exp_rdata);
            check({tag, "_err"}, m0_rsp_err, exp_err);
            check({tag, "_other_rsp"}, m1_rsp_valid, 0);
        end else begin
            check({tag, "_rsp_valid"}, m1_rsp_valid, 1);
            check({tag, "_rdata"}, m1_rsp_rdata, exp_rdata);
            check({tag, "_err"}, m1_rsp_err, exp_err);
            check({tag, "_other_rsp"}, m0_rsp_valid, 0);
        end
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int got;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        slv_rst = 1'b1;
        m0_rsp_ready = 1'b1;
        m1_rsp_ready = 1'b1;
        drive_cmd(0, 1'b1, 1'b1, 32'h10, '0, '0);
        drive_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) step();

        @(negedge clk);
        check("rst_m0_cmd_ready", m0_cmd_ready, 0);
        check("rst_s_cmd_valid", s_cmd_valid, 0);
        check("rst_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
        check("rst_state", dbg_state, ARB_IDLE);
        step();
        rst = 1'b0;
        slv_rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", m0_cmd_ready, 0);
        check("post_rst_s_cmd_valid", s_cmd_valid, 0);
        step();

        do_txn("rd_m0", 0, 1'b1, 32'h10, '0, '0, 32'hDEADBEEF, 1'b0);
        do_txn("wr_m1", 1, 1'b0, 32'h20, 32'h0000A55A, 4'b0011, 32'h0, 1'b0);
        do_txn("rdback_m1", 1, 1'b1, 32'h20, '0, '0, 32'h1234A55A, 1'b0);

        // Contention: both continuously valid, last grant was m1 so m0 goes first.
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        got = 0;
        drive_cmd(0, 1'b1, 1'b1, 32'h30, '0, '0);
        drive_cmd(1, 1'b1, 1'b1, 32'h34, '0, '0);
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge clk);
            if (m0_rsp_valid) begin
                check("cont_m0_rdata", m0_rsp_rdata, 32'hCAFE0001);
                check("cont_m0_excl", m1_rsp_valid, 0);
            end
            if (m1_rsp_valid) begin
                check("cont_m1_rdata", m1_rsp_rdata, 32'hCAFE0002);
                check("cont_m1_excl", m0_rsp_valid, 0);
            end
            if (m0_cmd_ready || m1_cmd_ready) begin
                check("cont_gnt", m1_cmd_ready, exp_q.pop_front());
                got++;
            end
            step();
        end
        check("cont_grants", got, 4);
        drive_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        drive_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("cont_last_rsp", {m1_rsp_valid, m1_rsp_rdata}, {1'b1, 32'hCAFE0002});
        step();

        // Back-pressure: m0 stalls its response; m1 must wait with cmd_ready low.
        m0_rsp_ready = 1'b0;
        drive_cmd(0, 1'b1, 1'b1, 32'h10, '0, '0);
        drive_cmd(1, 1'b1, 1'b1, 32'h34, '0, '0);
        @(negedge clk);
        check("bp_gnt", {m0_cmd_ready, m1_cmd_ready}, 2'b10);
        step();
        drive_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {m0_rsp_valid, m0_rsp_rdata, m1_cmd_ready}, {1'b1, 32'hDEADBEEF, 1'b0});
            step();
        end
        @(negedge clk);
        check("bp_still_valid", m0_rsp_valid, 1);
        m0_rsp_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_m1_gnt", {m1_cmd_ready, m0_rsp_valid}, 2'b10);
        step();
        drive_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("bp_m1_rsp", {m1_rsp_valid, m1_rsp_rdata}, {1'b1, 32'hCAFE0002});
        step();

        do_txn("err_wr", 0, 1'b0, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        do_txn("err_rd", 0, 1'b1, 32'h400, '0, '0, 32'h0, 1'b1);

        // Mid-operation reset while m1 holds off its response.
        m1_rsp_ready = 1'b0;
        drive_cmd(1, 1'b1, 1'b1, 32'h30, '0, '0);
        @(negedge clk);
        check("mr_m1_gnt", m1_cmd_ready, 1);
        step();
        drive_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("mr_in_rd", {m1_rsp_valid, dbg_state}, {1'b1, ARB_RD});
        step();
        rst = 1'b1;
        drive_cmd(0, 1'b1, 1'b1, 32'h10, '0, '0);
        drive_cmd(1, 1'b1, 1'b1, 32'h34, '0, '0);
        @(negedge clk);
        check("mr_rst_rsp", {m0_rsp_valid, m1_rsp_valid}, 2'b00);
        check("mr_rst_ready", {m0_cmd_ready, m1_cmd_ready}, 2'b00);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mr_after_rsp", {m0_rsp_valid, m1_rsp_valid}, 2'b00);
        check("mr_after_state", dbg_state, ARB_IDLE);
        check("mr_after_ready", {m0_cmd_ready, m1_cmd_ready}, 2'b00);
        m1_rsp_ready = 1'b1;
        step();
        @(negedge clk);
        check("mr_tie_gnt", {m0_cmd_ready, m1_cmd_ready}, 2'b10);
        step();
        drive_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        drive_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("mr_m0_rsp", {m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid}, {1'b1, 32'hDEADBEEF, 1'b0});
        step();
        check("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_icb_arb.md
Name: sram_icb_arb

Overview:
- Two-master ICB arbiter in front of the single-port SRAM slave.
- Shares the SRAM between the instruction-fetch port (m0) and the data/load-store port (m1) using round-robin grant.
- Allows one outstanding transaction at a time and routes each response back to the master that issued it.
- The SRAM slave only asserts rsp_valid for reads, so this block generates the write response locally. Every master sees exactly one rsp per cmd.

Parameters:
- ADDR_W, 32, ICB address width.
- DATA_W, 32, ICB data width; the write mask is DATA_W/8 bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- m0_icb_cmd_valid / m1_icb_cmd_valid  in  1  master cmd valid.
- m0_icb_cmd_ready / m1_icb_cmd_ready  out  1  master cmd ready.
- m0_icb_cmd_addr / m1_icb_cmd_addr  in  ADDR_W  byte address.
- m0_icb_cmd_read / m1_icb_cmd_read  in  1  1 = read, 0 = write.
- m0_icb_cmd_wdata / m1_icb_cmd_wdata  in  DATA_W  write data.
- m0_icb_cmd_wmask / m1_icb_cmd_wmask  in  DATA_W/8  byte strobes.
- m0_icb_rsp_valid / m1_icb_rsp_valid  out  1  response valid.
- m0_icb_rsp_ready / m1_icb_rsp_ready  in  1  response ready.
- m0_icb_rsp_err / m1_icb_rsp_err  out  1  response error.
- m0_icb_rsp_rdata / m1_icb_rsp_rdata  out  DATA_W  read data.
- s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask  out/in/out/out/out/out  same widths as above  cmd port to the SRAM slave.
- s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err, s_icb_rsp_rdata  in/out/in/in  same widths as above  rsp port from the SRAM slave.

Behaviour:
- Interface rule: one clock, clk. Reset rst is synchronous and active-high.
- Registered state: state (IDLE, RD, WRSP), owner (1 bit), last_gnt (1 bit), addr_q (ADDR_W), wr_err_q (1 bit).
- Reset values: state = IDLE, owner = 0, last_gnt = 1 (m0 wins the first tie), addr_q = 0, wr_err_q = 0.
- All mN_rsp_valid and mN_cmd_ready are 0 while rst is high and in the cycle after it. A reset in RD or WRSP abandons the transaction; no response is delivered.
- Grant (combinational, IDLE only):
  - If only one master is valid, that master is granted.
  - If both are valid, gnt = ~last_gnt.
  - If neither is valid, s_icb_cmd_valid = 0.
- IDLE cmd path:
  - s_icb_cmd_* = granted master's cmd fields.
  - s_icb_cmd_valid = granted master's valid.
  - Granted mN_cmd_ready = s_icb_cmd_ready. The other master's ready = 0.
- IDLE handshake (s_icb_cmd_valid & s_icb_cmd_ready): owner <= gnt, last_gnt <= gnt, addr_q <= cmd addr.
  - Read: state <= RD.
  - Write: state <= WRSP, wr_err_q <= s_icb_rsp_err sampled that cycle (the slave's err is combinational on address).
- Outside IDLE:
  - s_icb_cmd_valid = 0 and both mN_cmd_ready = 0.
  - s_icb_cmd_addr = addr_q, which keeps the slave's combinational err stable.
  - Other s_icb_cmd_* fields are don't-care; drive 0.
- RD state:
  - Owner's rsp_valid / err / rdata = s_icb_rsp_valid / err / rdata.
  - s_icb_rsp_ready = owner's rsp_ready.
  - On s_rsp_valid & s_rsp_ready: state <= IDLE.
- WRSP state:
  - Owner's rsp_valid = 1, rsp_rdata = 0, rsp_err = wr_err_q.
  - On owner's rsp_ready: state <= IDLE. s_icb_rsp_ready = 0.
- IDLE rsp handling: s_icb_rsp_ready = 1 to drain stray slave responses (e.g. after reset). These are never forwarded. Both mN_rsp_valid = 0.
- The non-owner master's rsp_valid is always 0. Its rdata = 0 and err = 0.
- Latency (SRAM slave with cmd_ready = 1):
  - Read: cmd handshake in cycle N, rsp_valid in cycle N+1.
  - Write: cmd handshake in cycle N, local rsp in cycle N+1.
  - Peak throughput is 1 transaction per 2 cycles.
- Back-pressure: a stalled rsp_ready holds the state indefinitely. The other master waits, and its cmd_ready stays 0.
- Fairness: with both masters continuously valid, grants alternate strictly m0, m1, m0, and so on. A lone requester is granted back-to-back.
- Protocol assumption: masters hold cmd fields stable while valid & ~ready. Dropping valid before handshake is a protocol violation; the block must not hang, and simply re-arbitrates.

Decomposition:
- Add to defines.v: `define ARB_IDLE 2'd0, ARB_RD 2'd1, ARB_WRSP 2'd2.
- Reuse the existing MemAddrBus and MemBus ranges.
- Sub-module: sram_icb_rr2, a 2-way round-robin grant (inputs req[1:0], last_gnt; output gnt), purely combinational.
- The FSM, address hold and response mux stay in sram_icb_arb.

Test Plan:
- Single read: after rst, m0 reads addr 0x10 holding 0xDEADBEEF -> m0_rsp_valid in cycle N+1 with rdata 0xDEADBEEF, err = 0; m1 sees no rsp.
- Write response generation: m1 writes 0x0000A55A with wmask 4'b0011 to 0x20 -> m1_rsp_valid in N+1 with rdata 0; a subsequent m1 read of 0x20 returns 0x....A55A in the low half and the old upper bytes.
- Contention: m0 and m1 both issue continuous reads -> grants alternate m0, m1, m0, m1 (first grant m0); each rsp appears only on the issuing master.
- Back-pressure: m0 read with m0_rsp_ready = 0 for 5 cycles -> m0 rsp_valid and rdata held for 5 cycles; m1_cmd_ready = 0 throughout; m1 is granted in the cycle after the m0 rsp handshake.
- Error: write to an address beyond SRamSize -> m0_rsp_err = 1 on the local write rsp; an out-of-range read gives rsp_err = 1.
- Mid-op reset: assert rst in RD with m1_rsp_ready = 0 -> next cycle both rsp_valid = 0, state IDLE, first tie afterwards grants m0.
